qmem_slave_mem: RTL and testbench

- Synthesizable QMEM slave: single-port word memory answering QMEM bus cycles (cs/we/sel/adr/dat_w, dat_r/ack/err).
- Programmable wait states.
- Flags out-of-range addresses with err.
- Standard bus-side target for the QMEM master testbench.
- Also serves as a simple on-chip RAM behind the CPU QMEM port.

---
 rtl/qmem_slave_mem_if.sv | 26 ++
 rtl/qmem_slave_mem.sv | 102 ++++++++++
 tb/tb_qmem_slave_mem.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/qmem_slave_mem_if.sv
// QMEM bus interface: master drives the request, slave returns
// read data plus a combinational ack/err terminator.
interface qmem_slave_mem_if #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW / 8
);
  logic           cs;
  logic           we;
  logic [QSW-1:0] sel;
  logic [QAW-1:0] adr;
  logic [QDW-1:0] dat_w;
  logic [QDW-1:0] dat_r;
  logic           ack;
  logic           err;

  modport master (
    output cs, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cs, we, sel, adr, dat_w,
    output dat_r, ack, err
  );
endinterface : qmem_slave_mem_if

// File: rtl/qmem_slave_mem.sv
// QMEM slave memory: single-port word RAM with byte-lane writes,
// programmable wait states and err for out-of-range addresses.
// Optional macro QMEM_SLAVE_LFSR_DLY_EN adds 0..3 pseudo-random
// extra wait states per access for master stress testing.
module qmem_slave_mem #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW / 8,
  parameter int AOW = 2,
  parameter int MAW = 10,
  parameter int DLY = 0,
  parameter int CW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  qmem_slave_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** MAW;

  logic [QDW-1:0] r_mem [DEPTH];
  logic [QDW-1:0] r_dat_r;
  logic [CW-1:0]  r_wcnt;
  logic [CW-1:0]  w_wcnt_nxt;
  logic [CW-1:0]  w_target;
  logic [MAW-1:0] w_word;
  logic           w_oor;
  logic           w_done;
  logic           w_ack;
  logic           w_err;

  assign w_word = bus.adr[MAW+AOW-1:AOW];
  assign w_oor  = |bus.adr[QAW-1:MAW+AOW];

`ifdef QMEM_SLAVE_LFSR_DLY_EN
  logic [7:0] r_lfsr;
  logic [1:0] r_xdly;
  logic [1:0] w_extra;

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block order.
    if (rst) r_lfsr <= 8'h01;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // Capture this access's extra delay in its first cs cycle so the
  // target stays stable while the counter runs.
  always_ff @(posedge clk) begin
    if (rst)                           r_xdly <= '0;
    else if (bus.cs && r_wcnt == '0)   r_xdly <= r_lfsr[1:0];
  end

  assign w_extra  = (r_wcnt == '0) ? r_lfsr[1:0] : r_xdly;
  assign w_target = CW'(DLY) + CW'(w_extra);
`else
  assign w_target = CW'(DLY);
`endif

  // Wait counter state register: IDLE/WAIT/DONE are encoded by cs and r_wcnt.
  always_ff @(posedge clk) begin
    if (rst) r_wcnt <= '0;
    else     r_wcnt <= w_wcnt_nxt;
  end

  // Terminate decode and next count; a finished or abandoned access
  // restarts from zero so back-to-back requests count afresh.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_done     = 1'b0;
    w_ack      = 1'b0;
    w_err      = 1'b0;
    w_wcnt_nxt = '0;
    w_done = ~rst & bus.cs & (r_wcnt == w_target);
    w_ack  = w_done & ~w_oor;
    w_err  = w_done &  w_oor;
    if (bus.cs && !w_done) w_wcnt_nxt = r_wcnt + CW'(1);
  end

  // Byte-lane write on the ack edge; only the lanes with sel set change.
  always_ff @(posedge clk) begin
    // NOTE: memory array carries no reset; contents are undefined at power-up.
    if (w_ack && bus.we) begin
      for (int i = 0; i < QSW; i++) begin
        if (bus.sel[i]) r_mem[w_word][i*8 +: 8] <= bus.dat_w[i*8 +: 8];
      end
    end
  end

  // Read data register: full word on read ack, zero on read err, else hold.
  always_ff @(posedge clk) begin
    if (rst)                    r_dat_r <= '0;
    else if (w_ack && !bus.we)  r_dat_r <= r_mem[w_word];
    else if (w_err && !bus.we)  r_dat_r <= '0;
  end

  assign bus.dat_r = r_dat_r;
  assign bus.ack   = w_ack;
  assign bus.err   = w_err;

endmodule : qmem_slave_mem

// File: tb/tb_qmem_slave_mem.sv
// Directed bench for qmem_slave_mem: three instances with DLY=0/3/5
// exercise zero-wait, wait-state and reset-during-access behaviour.
module tb_qmem_slave_mem;

  logic clk = 1'b0;
  logic rst0, rst3, rst5;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  qmem_slave_mem_if if0 ();
  qmem_slave_mem_if if3 ();
  qmem_slave_mem_if if5 ();

  qmem_slave_mem #(.DLY(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  qmem_slave_mem #(.DLY(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));
  qmem_slave_mem #(.DLY(5)) dut5 (.clk(clk), .rst(rst5), .bus(if5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the DLY=0 instance; leaves cs high just after the ack edge.
  task automatic bus0(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic exp_err, input string tag);
    int   cyc  = 0;
    logic seen = 1'b0;
    if0.cs = 1'b1; if0.we = we; if0.adr = adr; if0.sel = sel; if0.dat_w = dat;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (if0.ack || if0.err) begin
        seen = 1'b1;
        check({tag, "_err"}, if0.err, exp_err);
        check({tag, "_ack"}, if0.ack, !exp_err);
      end
      @(posedge clk); #1;
    end
    check({tag, "_seen"}, seen, 1);
`ifdef QMEM_SLAVE_LFSR_DLY_EN
    check({tag, "_lat_le4"}, (cyc <= 4), 1);
`else
    check({tag, "_lat"}, cyc, 1);
`endif
  endtask

  // Drop cs on the DLY=0 instance and check the registered read data.
  task automatic idle0_check(input string tag, input logic [31:0] exp);
    if0.cs = 1'b0;
    @(negedge clk);
    check(tag, if0.dat_r, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_mem [16];
    int          k;

    rst0 = 1'b1; rst3 = 1'b1; rst5 = 1'b1;
    if0.cs = 1'b1; if0.we = 1'b0; if0.adr = 32'h10; if0.sel = 4'hF; if0.dat_w = '0;
    if3.cs = 1'b0; if3.we = 1'b0; if3.adr = '0;    if3.sel = 4'hF; if3.dat_w = '0;
    if5.cs = 1'b0; if5.we = 1'b0; if5.adr = '0;    if5.sel = 4'hF; if5.dat_w = '0;

    // Reset: DLY=0 with cs high would otherwise ack at once, so this proves gating.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ack_gated", if0.ack, 0);
    check("rst_err_gated", if0.err, 0);
    check("rst_dat_r",     if0.dat_r, 0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst3 = 1'b0; rst5 = 1'b0;
    if0.cs = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write then read.
    bus0(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, "t1_wr");
    bus0(1'b0, 32'h10, 4'hF, 32'h0,        1'b0, "t1_rd");
    idle0_check("t1_rd_data", 32'hDEADBEEF);

    // sel=0 acks but leaves memory untouched.
    bus0(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, "sel0_wr");
    bus0(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, "sel0_rd");
    idle0_check("sel0_rd_data", 32'hDEADBEEF);

    // Byte lanes: lanes 0 and 2 overwritten.
    bus0(1'b1, 32'h20, 4'hF,    32'h11223344, 1'b0, "t3_wr_full");
    bus0(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, "t3_wr_lanes");
    bus0(1'b0, 32'h20, 4'hF,    32'h0,        1'b0, "t3_rd");
    idle0_check("t3_rd_data", 32'h11BB33DD);

    // Back-to-back writes with cs held high.
    bus0(1'b1, 32'h0, 4'hF, 32'hA0A00000, 1'b0, "t5_wr0");
    bus0(1'b1, 32'h4, 4'hF, 32'hB1B11111, 1'b0, "t5_wr4");
    bus0(1'b1, 32'h8, 4'hF, 32'hC2C22222, 1'b0, "t5_wr8");
    bus0(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, "t5_rd0");
    idle0_check("t5_rd0_data", 32'hA0A00000);
    bus0(1'b0, 32'h4, 4'hF, 32'h0, 1'b0, "t5_rd4");
    idle0_check("t5_rd4_data", 32'hB1B11111);
    bus0(1'b0, 32'h8, 4'hF, 32'h0, 1'b0, "t5_rd8");
    idle0_check("t5_rd8_data", 32'hC2C22222);

    // Top in-range word.
    bus0(1'b1, 32'hFFC, 4'hF, 32'h5A5A1234, 1'b0, "top_wr");
    bus0(1'b0, 32'hFFC, 4'hF, 32'h0,        1'b0, "top_rd");
    idle0_check("top_rd_data", 32'h5A5A1234);

    // Out of range: 0x1000 aliases word 0 in the index bits, which must stay intact.
    bus0(1'b1, 32'h1000, 4'hF, 32'h5, 1'b1, "t4_wr_oor");
    bus0(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, "t4_rd_oor");
    idle0_check("t4_rd_oor_data", 32'h0);
    bus0(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, "t4_rd0");
    idle0_check("t4_mem_unchanged", 32'hA0A00000);

`ifndef QMEM_SLAVE_LFSR_DLY_EN
    // DLY=3: ack exactly in the 4th cs-high cycle.
    if3.cs = 1'b1; if3.we = 1'b0; if3.adr = 32'h10;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_ack_c%0d", i), if3.ack, (i == 4));
      check($sformatf("t2_err_c%0d", i), if3.err, 0);
      @(posedge clk); #1;
    end
    if3.cs = 1'b0;

    // DLY=5: reset in the 3rd wait cycle, then a full fresh count.
    if5.cs = 1'b1; if5.we = 1'b0; if5.adr = 32'h0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check($sformatf("t6_pre_ack_c%0d", i), if5.ack, 0);
      @(posedge clk); #1;
    end
    rst5 = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check($sformatf("t6_rst_ack_c%0d", i), if5.ack, 0);
      @(posedge clk); #1;
    end
    rst5 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("t6_post_ack_c%0d", i), if5.ack, (i == 6));
      check($sformatf("t6_post_err_c%0d", i), if5.err, 0);
      @(posedge clk); #1;
    end
    if5.cs = 1'b0;
`else
    // Random extra wait states: every access still completes within DLY+4 cycles.
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = $urandom;
      bus0(1'b1, 32'h100 + 32'(i * 4), 4'hF, exp_mem[i], 1'b0, $sformatf("lf_wr%0d", i));
    end
    if0.cs = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n < 100; n++) begin
      k = $urandom_range(0, 15);
      bus0(1'b0, 32'h100 + 32'(k * 4), 4'hF, 32'h0, 1'b0, $sformatf("lf_rd%0d", n));
      idle0_check($sformatf("lf_rd%0d_data", n), exp_mem[k]);
    end
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_qmem_slave_mem
